// File: rtl/wb_pipe_select_pkg.sv
// Write-back select package: default widths and write-back source encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: default DATA_W/REG_AW/NUM_SRC/SEL_W and the WB_SEL_* source codes.
package wb_pipe_select_pkg;

  localparam int WB_DATA_W  = 16;
  localparam int WB_REG_AW  = 4;
  localparam int WB_NUM_SRC = 4;
  localparam int WB_SEL_W   = 3;

  // Source codes as packed by the memory stage; all-ones is the NOP code.
  localparam logic [WB_SEL_W-1:0] WB_SEL_ALU = 3'd0;
  localparam logic [WB_SEL_W-1:0] WB_SEL_MEM = 3'd1;
  localparam logic [WB_SEL_W-1:0] WB_SEL_PC  = 3'd2;
  localparam logic [WB_SEL_W-1:0] WB_SEL_IH  = 3'd3;
  localparam logic [WB_SEL_W-1:0] WB_SEL_NOP = {WB_SEL_W{1'b1}};

endpackage

// File: rtl/wb_src_mux.sv
// Purely combinational NUM_SRC:1 mux over a packed source bus.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: i_src_data (packed, source 0 in LSBs), i_sel (index),
//        o_data (selected word, 0 when out of range), o_out_of_range (i_sel >= NUM_SRC).
module wb_src_mux #(
  parameter int DATA_W  = 16,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 3
) (
  input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
  input  logic [SEL_W-1:0]          i_sel,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_out_of_range
);

  localparam logic [SEL_W-1:0] LAST_SRC = SEL_W'(NUM_SRC - 1);

  always_comb begin
    o_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_sel == SEL_W'(i)) begin
        o_data = i_src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign o_out_of_range = (i_sel > LAST_SRC);

endmodule

// File: rtl/wb_pipe_select.sv
// MEM/WB pipeline register with write-back source select, sticky illegal-select flag and bypass lookup.
// Latency: 1 cycle from inputs to wb_* outputs; forwarding outputs are combinational from registered state.
// Backpressure: stall holds every registered output; flush squashes the incoming instruction (flush wins).
// Ports: clk/rst (sync, active-high); stall, flush, in_valid, src_data, wb_sel, wb_en_in, wb_addr_in in;
//        wb_data, wb_addr, wb_we, wb_valid, sel_err out; fwd_a/b_addr in, fwd_a/b_hit and fwd_data out.
module wb_pipe_select
  import wb_pipe_select_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int REG_AW  = WB_REG_AW,
  parameter int NUM_SRC = WB_NUM_SRC,
  parameter int SEL_W   = WB_SEL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          wb_sel,
  input  logic                      wb_en_in,
  input  logic [REG_AW-1:0]         wb_addr_in,
  output logic [DATA_W-1:0]         wb_data,
  output logic [REG_AW-1:0]         wb_addr,
  output logic                      wb_we,
  output logic                      wb_valid,
  output logic                      sel_err,
  input  logic [REG_AW-1:0]         fwd_a_addr,
  input  logic [REG_AW-1:0]         fwd_b_addr,
  output logic                      fwd_a_hit,
  output logic                      fwd_b_hit,
  output logic [DATA_W-1:0]         fwd_data
);

  // The all-ones code is reserved for NOP, so every real source must sit below it.
  if (NUM_SRC >= (1 << SEL_W)) begin : g_bad_cfg
    $error("wb_pipe_select: NUM_SRC must be < 2**SEL_W");
  end

  logic [DATA_W-1:0] w_mux_data;
  logic              w_sel_oor;
  logic              w_sel_nop;
  logic              w_sel_illegal;

  logic [DATA_W-1:0] r_data;
  logic [REG_AW-1:0] r_addr;
  logic              r_we;
  logic              r_valid;
  logic              r_err;

  wb_src_mux #(
    .DATA_W  (DATA_W),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_src_mux (
    .i_src_data     (src_data),
    .i_sel          (wb_sel),
    .o_data         (w_mux_data),
    .o_out_of_range (w_sel_oor)
  );

  assign w_sel_nop     = (wb_sel == {SEL_W{1'b1}});
  assign w_sel_illegal = w_sel_oor & ~w_sel_nop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (flush) begin
      // Squash takes priority over stall; data/addr keep their last values.
      r_we    <= 1'b0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      if (!in_valid) begin
        r_we    <= 1'b0;
        r_valid <= 1'b0;
      end else if (!w_sel_oor) begin
        r_data  <= w_mux_data;
        r_addr  <= wb_addr_in;
        r_we    <= wb_en_in;
        r_valid <= 1'b1;
      end else begin
        // NOP and illegal selects both occupy the stage without writing.
        r_we    <= 1'b0;
        r_valid <= 1'b1;
        if (w_sel_illegal) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign wb_data  = r_data;
  assign wb_addr  = r_addr;
  assign wb_we    = r_we;
  assign wb_valid = r_valid;
  assign sel_err  = r_err;

  // r0 is deliberately not special-cased; the decoder never enables writes to it.
  assign fwd_a_hit = r_we & (fwd_a_addr == r_addr);
  assign fwd_b_hit = r_we & (fwd_b_addr == r_addr);
  assign fwd_data  = r_data;

endmodule
